// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS core.
// Moore machine that steps the shared datapath through fetch, decode and
// the per-class execute/writeback states, and counts retired instructions.
module multicycle_controller #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               instr_done,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_dec_state;
  logic [CNT_W-1:0] r_instret;
  logic             w_op_known;
  logic             w_pcwrite;
  logic             w_branch;
  logic             w_irwrite;
  logic             w_memwrite;
  logic             w_regwrite;
  logic             w_done;

  assign w_op_known = (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ) ||
                      (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_LW)  ||
                      (op == OP_SW);

  // State register; reset always restarts at FETCH.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  // Next-state selection; unknown opcodes retire as nops from DECODE.
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   w_state_next = S_MEMADR;
          OP_RTYPE:       w_state_next = S_EXECUTE;
          OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
          OP_ADDI:        w_state_next = S_ADDIEX;
          OP_J:           w_state_next = S_JUMP;
          default:        w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_state_next = S_MEMWB;
      S_EXECUTE: w_state_next = S_ALUWB;
      S_ADDIEX:  w_state_next = S_ADDIWB;
      default:   w_state_next = S_FETCH;
    endcase
  end

  // Moore output decode; during reset the selects show the FETCH pattern.
  always_comb begin
    w_dec_state = reset ? S_FETCH : r_state;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_done      = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    alucontrol  = ALU_ADD;
    case (w_dec_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        w_done  = ~w_op_known;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        case (funct)
          6'h20:   alucontrol = ALU_ADD;
          6'h22:   alucontrol = ALU_SUB;
          6'h24:   alucontrol = ALU_AND;
          6'h25:   alucontrol = ALU_OR;
          6'h2A:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        w_branch   = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // bne inverts the sense of the zero flag for the branch decision.
  assign pcen       = (w_pcwrite | (w_branch & (zero ^ (op == OP_BNE)))) & ~reset;
  assign irwrite    = w_irwrite & ~reset;
  assign memwrite   = w_memwrite & ~reset;
  assign regwrite   = w_regwrite & ~reset;
  assign instr_done = w_done & ~reset;
  assign state      = STATE_W'(r_state);
  assign instret    = r_instret;

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset)           r_instret <= '0;
    else if (instr_done) r_instret <= r_instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller.
// The driver pushes the expected per-cycle outputs; a negedge monitor checks.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;
  logic        pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic        instr_done;
  logic [3:0]  state;
  logic [31:0] instret;

  multicycle_controller #(.STATE_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .instr_done(instr_done), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       done;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctrl_t       ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  int          cur_state = 0;

  // Expected control word for a state, built field by field from the state table.
  function automatic ctrl_t model_ctrl(input int s, input logic [5:0] o,
                                       input logic [5:0] f, input logic z,
                                       input logic rst, input logic last);
    ctrl_t c;
    int    d;
    logic  pcwrite, branch;
    d = rst ? 0 : s;
    c = '0;
    c.aluc     = 3'b010;
    pcwrite    = (d == 0) || (d == 11);
    branch     = (d == 8);
    c.irwrite  = (d == 0);
    c.alusrcb  = (d == 0) ? 2'b01 : (d == 1) ? 2'b11 : (d == 2 || d == 9) ? 2'b10 : 2'b00;
    c.alusrca  = (d == 2) || (d == 9) || (d == 6) || (d == 8);
    c.iord     = (d == 3) || (d == 5);
    c.memtoreg = (d == 4);
    c.regwrite = (d == 4) || (d == 7) || (d == 10);
    c.memwrite = (d == 5);
    c.regdst   = (d == 7);
    c.pcsrc    = (d == 8) ? 2'b01 : (d == 11) ? 2'b10 : 2'b00;
    if (d == 8) c.aluc = 3'b110;
    if (d == 6) begin
      case (f)
        6'h22:   c.aluc = 3'b110;
        6'h24:   c.aluc = 3'b000;
        6'h25:   c.aluc = 3'b001;
        6'h2A:   c.aluc = 3'b111;
        default: c.aluc = 3'b010;
      endcase
    end
    c.pcen = pcwrite | (branch & (z ^ (o == 6'h05)));
    c.done = last;
    if (rst) begin
      c.pcen = 1'b0; c.irwrite = 1'b0; c.memwrite = 1'b0;
      c.regwrite = 1'b0; c.done = 1'b0;
    end
    return c;
  endfunction

  // Hold reset for n cycles after the current edge.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      sb_q.push_back({4'(cur_state), model_ctrl(cur_state, op, funct, zero, 1'b1, 1'b0), 32'(model_cnt)});
      cur_state = 0;
      model_cnt = 0;
    end
  endtask

  // One instruction; abort_at >= 0 asserts reset in that cycle of the sequence.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int abort_at);
    int seq[$];
    case (o)
      6'h23:        seq = {0, 1, 2, 3, 4};
      6'h2B:        seq = {0, 1, 2, 5};
      6'h00:        seq = {0, 1, 6, 7};
      6'h08:        seq = {0, 1, 9, 10};
      6'h04, 6'h05: seq = {0, 1, 8};
      6'h02:        seq = {0, 1, 11};
      default:      seq = {0, 1};
    endcase
    $display("instr op=%02h funct=%02h zero=%0d cycles=%0d abort=%0d", o, f, z, seq.size(), abort_at);
    for (int k = 0; k < seq.size(); k++) begin
      @(posedge clk); #1;
      cur_state = seq[k];
      if (k == abort_at) begin
        reset = 1'b1;
        op = o; funct = f; zero = 1'($urandom);
        sb_q.push_back({4'(cur_state), model_ctrl(cur_state, op, funct, zero, 1'b1, 1'b0), 32'(model_cnt)});
        cur_state = 0;
        model_cnt = 0;
        return;
      end
      reset = 1'b0;
      op    = (k == 0) ? 6'($urandom) : o;
      funct = (k == 0) ? 6'($urandom) : f;
      zero  = (seq[k] == 8) ? z : 1'($urandom);
      sb_q.push_back({4'(cur_state),
                      model_ctrl(cur_state, op, funct, zero, 1'b0, k == seq.size() - 1),
                      32'(model_cnt)});
      if (k == seq.size() - 1) model_cnt++;
    end
    cur_state = 0;
  endtask

  // Monitor: pop one expectation per cycle and compare with the DUT.
  always @(negedge clk) begin
    exp_t  e;
    ctrl_t a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, alucontrol, instr_done};
      n_checks++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
      end
      n_checks++;
      if (a !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl t=%0t st=%0d got=%h exp=%h", $time, e.st, a, e.ctrl);
      end
      n_checks++;
      if (instret !== e.cnt) begin
        n_fail++;
        $display("FAIL instret t=%0t got=%0d exp=%0d", $time, instret, e.cnt);
      end
    end
  end

  logic [5:0] known_ops [7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
  logic [5:0] functs    [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

  initial begin
    logic [5:0] o, f;
    do_reset(2);
    run_instr(6'h23, 6'h00, 1'b0, -1);
    run_instr(6'h00, 6'h2A, 1'b0, -1);
    run_instr(6'h04, 6'h00, 1'b1, -1);
    run_instr(6'h04, 6'h00, 1'b0, -1);
    run_instr(6'h05, 6'h00, 1'b0, -1);
    run_instr(6'h05, 6'h00, 1'b1, -1);
    run_instr(6'h2B, 6'h00, 1'b0, -1);
    run_instr(6'h3F, 6'h00, 1'b0, -1);
    run_instr(6'h02, 6'h00, 1'b0, -1);
    run_instr(6'h08, 6'h00, 1'b0, -1);
    for (int i = 0; i < 6; i++) run_instr(6'h00, functs[i], 1'b0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 3);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 7) == 7) begin
        do o = 6'($urandom); while (o inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02});
      end else begin
        o = known_ops[$urandom_range(0, 6)];
      end
      f = functs[$urandom_range(0, 5)];
      run_instr(o, f, 1'($urandom), -1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (instret !== 32'd20) begin
      n_fail++;
      $display("FAIL instret_after_mix got=%0d exp=20", instret);
    end
    @(negedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
